priv_int_arbiter: RTL and testbench

- Parametrised N-source interrupt arbiter for the privilege unit; the next-generation replacement for the fixed six-source interrupt front end.
- Latches pending interrupts per source, with edge or level capture selected per source.
- Selects a winner by fixed priority or round-robin and holds the request until the pipeline clears.
- Emits a single-cycle take pulse for mepc/mstatus update and blocks re-entry until mret.

---
 rtl/priv_int_arbiter.sv | 148 ++++++++++++++
 tb/tb_priv_int_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_int_arbiter.sv
// priv_int_arbiter: N-source interrupt front end for the privilege unit.
// Captures pending interrupts (edge or level per source), arbitrates by fixed
// priority or round-robin, holds the request until the pipeline drains and
// blocks re-entry until mret.
module priv_int_arbiter #(
  parameter int unsigned        N_SRC      = 8,
  parameter logic [N_SRC-1:0]   EDGE_MASK  = '0,
  parameter bit                 RR_MODE    = 1'b0,
  parameter int unsigned        CAUSE_W    = 5,
  parameter int unsigned        CAUSE_BASE = 0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [N_SRC-1:0]   int_src,
  input  logic [N_SRC-1:0]   int_en,
  input  logic               global_ie,
  input  logic [N_SRC-1:0]   sw_clear,
  input  logic               exception,
  input  logic               pipe_clear,
  input  logic               mret,
  output logic               irq_req,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic               take_pulse,
  output logic [N_SRC-1:0]   pending,
  output logic               in_service
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [N_SRC-1:0]   prev;
  logic               hist_vld;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   take_clr;
  logic [N_SRC-1:0]   pend_nxt;
  logic [N_SRC-1:0]   eligible;
  logic [IDX_W-1:0]   win_c;
  logic               win_vld_c;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_nxt;

  // Edge history; hist_vld masks the first cycle after reset so a line held
  // high through reset is not seen as a fresh rising edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prev     <= '0;
      hist_vld <= 1'b0;
    end else begin
      prev     <= int_src;
      hist_vld <= 1'b1;
    end
  end

  // Next pending vector: edge sources are sticky (set beats clear), level
  // sources simply follow the registered line.
  always_comb begin
    rise     = int_src & ~prev & {N_SRC{hist_vld}};
    take_clr = '0;
    if (state == REQ && pipe_clear) begin
      take_clr = N_SRC'(1) << win_q;
    end
    pend_nxt = (EDGE_MASK & (rise | (pending & ~sw_clear & ~take_clr)))
             | (~EDGE_MASK & int_src);
  end

  // Pending register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

  // Winner selection: descending scan so the last hit is the preferred one.
  always_comb begin
    eligible  = pending & int_en;
    win_c     = '0;
    win_vld_c = 1'b0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (RR_MODE) begin
        if (eligible[(int'(rr_ptr) + k) % int'(N_SRC)]) begin
          win_c     = IDX_W'((int'(rr_ptr) + k) % int'(N_SRC));
          win_vld_c = 1'b1;
        end
      end else if (eligible[k]) begin
        win_c     = IDX_W'(k);
        win_vld_c = 1'b1;
      end
    end
    rr_nxt = (win_c == IDX_W'(N_SRC - 1)) ? '0 : win_c + IDX_W'(1);
  end

  // Trap-entry FSM with registered request, cause, strobe and service flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_cause  <= '0;
      take_pulse <= 1'b0;
      in_service <= 1'b0;
      win_q      <= '0;
      rr_ptr     <= '0;
    end else begin
      take_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (global_ie && win_vld_c && !exception) begin
            state      <= REQ;
            irq_req    <= 1'b1;
            take_pulse <= 1'b1;
            win_q      <= win_c;
            irq_cause  <= CAUSE_W'(CAUSE_BASE + 32'(win_c));
            if (RR_MODE) begin
              rr_ptr <= rr_nxt;
            end
          end
        end
        REQ: begin
          if (pipe_clear) begin
            state      <= SERVICE;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (mret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priv_int_arbiter.sv
// Directed bench for priv_int_arbiter: one fixed-priority edge instance and
// one round-robin level instance, with a cause scoreboard keyed on take_pulse.
module tb_priv_int_arbiter;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] f_src, r_src, int_en, sw_clear;
  logic       global_ie, exception, pipe_clear, mret;

  logic       f_req, f_take, f_svc;
  logic [4:0] f_cause;
  logic [7:0] f_pend;
  logic       r_req, r_take, r_svc;
  logic [4:0] r_cause;
  logic [7:0] r_pend;

  int errors = 0;
  int checks = 0;
  int f_q[$];
  int r_q[$];
  logic f_take_d = 1'b0;
  logic r_take_d = 1'b0;

  always #5 CLK = ~CLK;

  priv_int_arbiter #(.N_SRC(8), .EDGE_MASK(8'hFF), .RR_MODE(1'b0),
                     .CAUSE_W(5), .CAUSE_BASE(0)) u_fix (
    .CLK(CLK), .nRST(nRST), .int_src(f_src), .int_en(int_en),
    .global_ie(global_ie), .sw_clear(sw_clear), .exception(exception),
    .pipe_clear(pipe_clear), .mret(mret), .irq_req(f_req),
    .irq_cause(f_cause), .take_pulse(f_take), .pending(f_pend),
    .in_service(f_svc));

  priv_int_arbiter #(.N_SRC(8), .EDGE_MASK(8'h00), .RR_MODE(1'b1),
                     .CAUSE_W(5), .CAUSE_BASE(0)) u_rr (
    .CLK(CLK), .nRST(nRST), .int_src(r_src), .int_en(int_en),
    .global_ie(global_ie), .sw_clear(sw_clear), .exception(exception),
    .pipe_clear(pipe_clear), .mret(mret), .irq_req(r_req),
    .irq_cause(r_cause), .take_pulse(r_take), .pending(r_pend),
    .in_service(r_svc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic finish_trap();
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  // Scoreboard: every take_pulse pops one expected cause; strobe must be 1 cycle.
  always @(negedge CLK) begin
    if (f_take) begin
      chk("f_take_width", 32'(f_take_d), 0);
      chk("f_sb_nonempty", 32'(f_q.size() > 0), 1);
      if (f_q.size() > 0) chk("f_sb_cause", 32'(f_cause), f_q.pop_front());
    end
    if (r_take) begin
      chk("r_take_width", 32'(r_take_d), 0);
      chk("r_sb_nonempty", 32'(r_q.size() > 0), 1);
      if (r_q.size() > 0) chk("r_sb_cause", 32'(r_cause), r_q.pop_front());
    end
    f_take_d = f_take;
    r_take_d = r_take;
  end

  initial begin
    nRST = 1'b0;
    f_src = '0; r_src = '0; sw_clear = '0;
    int_en = 8'hFF; global_ie = 1'b1;
    exception = 1'b0; pipe_clear = 1'b0; mret = 1'b0;
    #12;
    chk("rst_req", 32'(f_req), 0);
    chk("rst_take", 32'(f_take), 0);
    chk("rst_cause", 32'(f_cause), 0);
    chk("rst_pend", 32'(f_pend), 0);
    chk("rst_svc", 32'(f_svc), 0);
    chk("rst_r_req", 32'(r_req), 0);
    nRST = 1'b1;
    tick();

    // Basic edge on source 3
    f_q.push_back(3);
    f_src = 8'h08;
    tick();
    f_src = 8'h00;
    chk("e3_pend", 32'(f_pend), 32'h08);
    chk("e3_noreq_yet", 32'(f_req), 0);
    tick();
    chk("e3_req", 32'(f_req), 1);
    chk("e3_take", 32'(f_take), 1);
    chk("e3_cause", 32'(f_cause), 3);
    tick();
    chk("e3_take_gone", 32'(f_take), 0);
    chk("e3_req_held", 32'(f_req), 1);
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("e3_pend_clr", 32'(f_pend), 0);
    chk("e3_svc", 32'(f_svc), 1);
    chk("e3_req_off", 32'(f_req), 0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("e3_idle", 32'(f_svc), 0);

    // Fixed priority: 2 then 5; hold with int_en dropped and exception in REQ
    f_q.push_back(2);
    f_q.push_back(5);
    f_src = 8'h24;
    tick();
    f_src = 8'h00;
    chk("pri_pend", 32'(f_pend), 32'h24);
    tick();
    chk("pri_cause2", 32'(f_cause), 2);
    chk("pri_take2", 32'(f_take), 1);
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("pri_pend5", 32'(f_pend), 32'h20);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    tick();
    chk("pri_req5", 32'(f_req), 1);
    chk("pri_cause5", 32'(f_cause), 5);
    int_en = 8'h00;
    exception = 1'b1;
    tick();
    tick();
    chk("hold_req", 32'(f_req), 1);
    chk("hold_cause", 32'(f_cause), 5);
    int_en = 8'hFF;
    exception = 1'b0;
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("hold_svc", 32'(f_svc), 1);
    chk("hold_pend", 32'(f_pend), 0);
    mret = 1'b1;
    tick();
    mret = 1'b0;

    // Exception blocks arbitration for one cycle
    f_q.push_back(3);
    f_src = 8'h08;
    tick();
    f_src = 8'h00;
    exception = 1'b1;
    tick();
    chk("exc_block", 32'(f_req), 0);
    exception = 1'b0;
    tick();
    chk("exc_req", 32'(f_req), 1);
    chk("exc_cause", 32'(f_cause), 3);
    finish_trap();

    // global_ie off, sw_clear vs new edge
    global_ie = 1'b0;
    f_src = 8'h10;
    tick();
    f_src = 8'h00;
    tick();
    tick();
    chk("gie_noreq", 32'(f_req), 0);
    chk("gie_pend", 32'(f_pend), 32'h10);
    f_src = 8'h08;
    sw_clear = 8'h08;
    tick();
    f_src = 8'h00;
    sw_clear = 8'h00;
    chk("setwins_pend", 32'(f_pend), 32'h18);
    sw_clear = 8'h10;
    tick();
    sw_clear = 8'h00;
    chk("swclr_pend", 32'(f_pend), 32'h08);
    f_q.push_back(3);
    global_ie = 1'b1;
    tick();
    chk("gie_req", 32'(f_req), 1);
    chk("gie_cause", 32'(f_cause), 3);
    finish_trap();
    chk("gie_pend_done", 32'(f_pend), 0);

    // No nesting: edge during SERVICE waits for mret; pipe_clear in first REQ cycle
    f_q.push_back(1);
    f_src = 8'h02;
    tick();
    f_src = 8'h00;
    tick();
    chk("nest_cause1", 32'(f_cause), 1);
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("nest_svc", 32'(f_svc), 1);
    f_q.push_back(6);
    f_src = 8'h40;
    tick();
    f_src = 8'h00;
    chk("nest_pend6", 32'(f_pend), 32'h40);
    tick();
    chk("nest_noreq", 32'(f_req), 0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("nest_idle_noreq", 32'(f_req), 0);
    tick();
    chk("nest_req6", 32'(f_req), 1);
    chk("nest_take6", 32'(f_take), 1);
    chk("nest_cause6", 32'(f_cause), 6);
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("short_req_svc", 32'(f_svc), 1);
    chk("short_req_off", 32'(f_req), 0);
    mret = 1'b1;
    tick();
    mret = 1'b0;

    // Reset during REQ, source 0 held high through reset
    f_q.push_back(2);
    f_src = 8'h04;
    tick();
    f_src = 8'h00;
    tick();
    tick();
    chk("rreq_req", 32'(f_req), 1);
    f_src = 8'h01;
    #2 nRST = 1'b0;
    #1;
    chk("rreq_req0", 32'(f_req), 0);
    chk("rreq_cause0", 32'(f_cause), 0);
    chk("rreq_pend0", 32'(f_pend), 0);
    chk("rreq_take0", 32'(f_take), 0);
    tick();
    nRST = 1'b1;
    tick();
    tick();
    tick();
    chk("no_spur_pend", 32'(f_pend), 0);
    chk("no_spur_req", 32'(f_req), 0);
    f_src = 8'h00;
    tick();

    // Reset during SERVICE
    f_q.push_back(2);
    f_src = 8'h04;
    tick();
    f_src = 8'h00;
    tick();
    chk("rsvc_req", 32'(f_req), 1);
    pipe_clear = 1'b1;
    tick();
    pipe_clear = 1'b0;
    chk("rsvc_svc", 32'(f_svc), 1);
    #2 nRST = 1'b0;
    #1;
    chk("rsvc_svc0", 32'(f_svc), 0);
    chk("rsvc_req0", 32'(f_req), 0);
    chk("rsvc_pend0", 32'(f_pend), 0);
    tick();
    nRST = 1'b1;
    tick();
    tick();

    // Round-robin over level sources 1 and 6, then wrap from ptr 7 to source 0
    r_q.push_back(1);
    r_q.push_back(6);
    r_q.push_back(1);
    r_q.push_back(6);
    r_src = 8'h42;
    tick();
    chk("rr_pend", 32'(r_pend), 32'h42);
    tick();
    chk("rr_g1", 32'(r_cause), 1);
    finish_trap();
    tick();
    chk("rr_g6", 32'(r_cause), 6);
    finish_trap();
    tick();
    chk("rr_g1b", 32'(r_cause), 1);
    chk("rr_lvl_pend", 32'(r_pend), 32'h42);
    finish_trap();
    tick();
    chk("rr_g6b", 32'(r_cause), 6);
    r_q.push_back(0);
    r_src = 8'h01;
    finish_trap();
    tick();
    chk("rr_wrap_req", 32'(r_req), 1);
    chk("rr_wrap0", 32'(r_cause), 0);
    r_src = 8'h00;
    finish_trap();
    tick();

    chk("f_sb_empty", 32'(f_q.size()), 0);
    chk("r_sb_empty", 32'(r_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
